// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Groups the IR / control-strobe bundle between the hardwired control
//   sequencer and the 32-bit bus datapath.
//   Ports (as seen from the sequencer, modport master):
//     in : IR[31:0], Mem_ready, Stop
//     out: PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout,
//          IRin, Yin, Rin_sel, Rout_sel, ALU_op, Run, Illegal, Instr_count
//   The datapath/bench side uses modport slave.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
);
  logic [31:0]         IR;
  logic                Mem_ready;
  logic                Stop;
  logic                PCout;
  logic                MARin;
  logic                IncPC;
  logic                Zin;
  logic                Zlowout;
  logic                PCin;
  logic                Read;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                Yin;
  logic [NUM_REGS-1:0] Rin_sel;
  logic [NUM_REGS-1:0] Rout_sel;
  logic [OPW-1:0]      ALU_op;
  logic                Run;
  logic                Illegal;
  logic [15:0]         Instr_count;

  modport master (
    input  IR, Mem_ready, Stop,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout,
           IRin, Yin, Rin_sel, Rout_sel, ALU_op, Run, Illegal, Instr_count
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout,
           IRin, Yin, Rin_sel, Rout_sel, ALU_op, Run, Illegal, Instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit: T0-T2 instruction fetch, T3-T5 register-register
//   ALU execute. Strobes and one-hot register selects are a Moore decode of
//   the state register and the IR fields.
//   Ports:
//     Clock  - rising-edge clock
//     Reset  - synchronous, active-high
//     bus    - control_sequencer_if.master (IR, Mem_ready, Stop in;
//              datapath strobes, Rin_sel/Rout_sel, ALU_op, Run, Illegal,
//              Instr_count out)
//   Optional feature macro: CU_MEM_WAIT_EN - when defined, T1 holds until
//   Mem_ready = 1; otherwise T1 is a single cycle and Mem_ready is ignored.
module control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  control_sequencer_if.master   bus
);

  localparam logic [2:0] ST_RST  = 3'd0;
  localparam logic [2:0] ST_T0   = 3'd1;
  localparam logic [2:0] ST_T1   = 3'd2;
  localparam logic [2:0] ST_T2   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam logic [2:0] ST_T5   = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [2:0]  state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;

  logic [4:0]  opcode_s;
  logic        op_alu_s;
  logic        op_legal_s;

  // One-hot decode of a 4-bit register field.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign opcode_s   = bus.IR[31:27];
  // ALU opcodes occupy the contiguous range ADD (00011) .. ROL (01010).
  assign op_alu_s   = (opcode_s >= 5'd3) && (opcode_s <= 5'd10);
  assign op_legal_s = op_alu_s || (opcode_s == OP_NOP) || (opcode_s == OP_HALT);

  // Next-state, sticky illegal flag and retired-instruction counter.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1: begin
`ifdef CU_MEM_WAIT_EN
        if (bus.Mem_ready) begin
          state_d = ST_T2;
        end else begin
          state_d = ST_T1;
        end
`else
        state_d = ST_T2;
`endif
      end
      ST_T2:  state_d = ST_T3;
      ST_T3: begin
        if (op_alu_s) begin
          state_d = ST_T4;
        end else begin
          if (!op_legal_s) begin
            illegal_d = 1'b1;
          end else begin
            illegal_d = illegal_q;
          end
          // A HALT opcode and a Stop request both end at HALT.
          if ((opcode_s == OP_HALT) || bus.Stop) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_T0;
          end
        end
      end
      ST_T4:  state_d = ST_T5;
      ST_T5: begin
        count_d = count_q + 16'd1;
        if (bus.Stop) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_RST;
      illegal_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Moore decode of strobes and register selects from state and IR.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Rin_sel  = '0;
    bus.Rout_sel = '0;
    bus.ALU_op   = '0;
    bus.Run      = 1'b0;
    case (state_q)
      ST_T0: begin
        bus.Run   = 1'b1;
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      ST_T1: begin
        bus.Run     = 1'b1;
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      ST_T2: begin
        bus.Run    = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        bus.Run = 1'b1;
        // Non-ALU opcodes finish here with every strobe suppressed.
        if (op_alu_s) begin
          bus.Rout_sel = onehot(bus.IR[22:19]);
          bus.Yin      = 1'b1;
        end else begin
          bus.Yin      = 1'b0;
        end
      end
      ST_T4: begin
        bus.Run      = 1'b1;
        bus.Rout_sel = onehot(bus.IR[18:15]);
        bus.Zin      = 1'b1;
        bus.ALU_op   = OPW'(opcode_s);
      end
      ST_T5: begin
        bus.Run     = 1'b1;
        bus.Zlowout = 1'b1;
        bus.Rin_sel = onehot(bus.IR[26:23]);
      end
      default: begin
        bus.Run = 1'b0;
      end
    endcase
  end

  assign bus.Illegal     = illegal_q;
  assign bus.Instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Randomized bench: random instruction words, Stop, Reset and Mem_ready
//   drive the sequencer; a cycle-level reference model (instruction phase
//   counter plus halted flag) predicts every output each cycle.
module tb_control_sequencer;

  localparam int NUM_REGS = 16;
  localparam int OPW      = 5;
  localparam int N_CYCLES = 4000;

`ifdef CU_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  // reference model state: ph = -1 reset cycle, 0..5 = T0..T5
  int          m_ph;
  bit          m_halted;
  bit          m_valid;
  bit          m_ill;
  int          m_cnt;

  control_sequencer_if #(.NUM_REGS(NUM_REGS), .OPW(OPW)) bus ();

  control_sequencer #(.NUM_REGS(NUM_REGS), .OPW(OPW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_alu(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd10);
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return is_alu(op) || (op == 5'd26) || (op == 5'd27);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input bit r, input bit s, input bit mr, input logic [31:0] irv);
    logic [4:0] op;
    op = irv[31:27];
    if (r) begin
      m_ph = -1; m_halted = 1'b0; m_ill = 1'b0; m_cnt = 0; m_valid = 1'b1;
    end else if (m_valid && !m_halted) begin
      case (m_ph)
        -1: m_ph = 0;
        0:  m_ph = 1;
        1:  m_ph = (WAIT_EN && !mr) ? 1 : 2;
        2:  m_ph = 3;
        3: begin
          if (is_alu(op)) m_ph = 4;
          else begin
            if (!is_legal(op)) m_ill = 1'b1;
            if (op == 5'd27 || s) m_halted = 1'b1;
            else m_ph = 0;
          end
        end
        4: m_ph = 5;
        5: begin
          m_cnt = (m_cnt + 1) % 65536;
          if (s) m_halted = 1'b1;
          else m_ph = 0;
        end
        default: m_ph = -1;
      endcase
    end
  endtask

  // Random instruction word: mostly ALU ops, some NOP/HALT/illegal.
  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 99);
    if (k < 60)      w[31:27] = 5'($urandom_range(3, 10));
    else if (k < 75) w[31:27] = 5'd26;
    else if (k < 80) w[31:27] = 5'd27;
    else begin
      w[31:27] = 5'($urandom_range(0, 31));
      if (is_legal(w[31:27])) w[31:27] = 5'd31;
    end
    return w;
  endfunction

  task automatic check_outputs();
    logic [10:0] exp_strb, obs_strb;
    logic [15:0] exp_rin, exp_rout;
    logic [4:0]  exp_alu;
    logic        exp_run;
    logic [4:0]  op;
    op = bus.IR[31:27];
    exp_strb = 11'd0; exp_rin = 16'd0; exp_rout = 16'd0; exp_alu = 5'd0;
    exp_run  = (!m_halted) && (m_ph >= 0);
    // strobe order: PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin Yin
    if (exp_run) begin
      case (m_ph)
        0: exp_strb = 11'b111_1000_0000;
        1: exp_strb = 11'b000_0111_1000;
        2: exp_strb = 11'b000_0000_0110;
        3: if (is_alu(op)) begin
             exp_strb = 11'b000_0000_0001;
             exp_rout = 16'd1 << bus.IR[22:19];
           end
        4: begin
             exp_strb = 11'b000_1000_0000;
             exp_rout = 16'd1 << bus.IR[18:15];
             exp_alu  = op;
           end
        5: begin
             exp_strb = 11'b000_0100_0000;
             exp_rin  = 16'd1 << bus.IR[26:23];
           end
        default: exp_strb = 11'd0;
      endcase
    end
    obs_strb = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin,
                bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin};
    check_val("strobes",     32'(obs_strb),        32'(exp_strb));
    check_val("rin_sel",     32'(bus.Rin_sel),     32'(exp_rin));
    check_val("rout_sel",    32'(bus.Rout_sel),    32'(exp_rout));
    check_val("alu_op",      32'(bus.ALU_op),      32'(exp_alu));
    check_val("run",         32'(bus.Run),         32'(exp_run));
    check_val("illegal",     32'(bus.Illegal),     32'(m_ill));
    check_val("instr_count", 32'(bus.Instr_count), 32'(m_cnt));
  endtask

  initial begin
    bit          r_at, s_at, mr_at;
    logic [31:0] ir_at;
    n_vec = 0; n_err = 0;
    m_ph = -1; m_halted = 1'b0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = 0;
    rst = 1'b1;
    bus.IR = 32'h2891_8000;
    bus.Stop = 1'b0;
    bus.Mem_ready = 1'b1;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      r_at = rst; s_at = bus.Stop; mr_at = bus.Mem_ready; ir_at = bus.IR;
      @(posedge clk);
      #1;
      model_step(r_at, s_at, mr_at, ir_at);
      // new stimulus for the coming edge
      if (cyc < 3)          rst = 1'b1;
      else if (m_halted)    rst = ($urandom_range(0, 3) == 0);
      else                  rst = ($urandom_range(0, 59) == 0);
      bus.Stop      = ($urandom_range(0, 19) == 0);
      bus.Mem_ready = ($urandom_range(0, 9) < 7);
      if (m_ph == 0 && !m_halted) bus.IR = (cyc < 10) ? 32'h2891_8000 : rand_ir();
      #1;
      if (m_valid) check_outputs();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
